mem_access_stage: RTL

Parametrised successor to the pipeline's pass-through memory stage. Sits between the EX/MEM and MEM/WB boundaries. Owns the data-memory handshake (request/acknowledge with arbitrary wait states and a timeout), generates big-endian byte enables for sub-word stores, aligns and sign/zero-extends sub-word loads, stalls upstream while an access is outstanding, and registers all WB-bound fields.

---
 rtl/mem_access_stage.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Purpose     : pipeline MEM stage; data-memory req/ack handshake with timeout, big-endian sub-word stores and loads, registered WB fields.
// Latency     : 1 cycle for non-memory ops; memory ops take 2 cycles plus 1 per wait state (or TIMEOUT+1 cycles on bus error).
// Backpressure: stall_out holds upstream from acceptance of a memory op until the cycle that acks or times out it.
//
// Ports: clk/reset (sync, active-high); EX/MEM fields *_in; dmem_* data-memory request bus (dmem_req registered);
//        stall_out to upstream; MEM/WB fields *_out, all registered, plus single-cycle buserr_out / misalign_out.
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
// Bit numbering is big-endian throughout: bit 0 is the MSB, byte lane 0 is bits [0:7] at address offset 0.
module mem_access_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [0:31]       nextPC_in,
    input  logic [0:4]        destReg_in,
    input  logic [0:31]       aluResult_in,
    input  logic [0:31]       storeData_in,
    input  logic              PCtoReg_in,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    input  logic              MemWrite_in,
    input  logic              loadSign_in,
    input  logic [0:1]        DSize_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [0:ADDR_W-1] dmem_addr,
    output logic [0:31]       dmem_wdata,
    output logic [0:3]        dmem_be,
    input  logic [0:31]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_out,
    output logic              valid_out,
    output logic              PCtoReg_out,
    output logic              RegWrite_out,
    output logic              MemToReg_out,
    output logic [0:31]       nextPC_out,
    output logic [0:31]       aluResult_out,
    output logic [0:31]       dataOut_out,
    output logic [0:4]        destReg_out,
    output logic              buserr_out,
    output logic              misalign_out
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    // waitCnt counts completed no-ack ACCESS cycles; the timeout fires in the
    // TIMEOUT-th ACCESS cycle, i.e. while waitCnt == TIMEOUT-1.
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef struct packed {
        logic [0:31]       nextPC;
        logic [0:4]        destReg;
        logic [0:31]       aluResult;
        logic [0:31]       wdata;
        logic [0:3]        be;
        logic [0:ADDR_W-1] addr;
        logic [0:1]        dSize;
        logic              loadSign;
        logic              pcToReg;
        logic              regWrite;
        logic              memToReg;
        logic              memWrite;
    } hold_t;

    logic [0:0]       stateQ;
    logic [CNT_W-1:0] waitCnt;
    hold_t            holdQ;
    hold_t            holdD;

    logic        memOp;
    logic        misalign;
    logic        isHalf;
    logic        isWord;
    logic        inAccess;
    logic        timeoutHit;
    logic [0:1]  inOff;
    logic [0:1]  effOff;
    logic [0:1]  heldOff;
    logic [0:7]  laneB;
    logic [0:15] laneH;
    logic [0:31] loadData;

    // Request-side decode: everything the ACCESS phase drives is precomputed
    // here and captured in holdQ so the dmem bus comes straight from flops.
    always_comb begin
        isHalf = (DSize_in == 2'b01);
        isWord = DSize_in[0];
        memOp  = valid_in & (MemToReg_in | MemWrite_in);
        inOff  = aluResult_in[30:31];
        effOff = isWord ? 2'b00 : (isHalf ? {inOff[0], 1'b0} : inOff);
`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned exactly when forcing alignment would change the offset.
        misalign = memOp & (effOff != inOff);
`else
        misalign = 1'b0;
`endif
        holdD.nextPC    = nextPC_in;
        holdD.destReg   = destReg_in;
        holdD.aluResult = aluResult_in;
        holdD.addr      = aluResult_in[32-ADDR_W:31];
        holdD.addr[ADDR_W-2:ADDR_W-1] = effOff;
        holdD.dSize     = DSize_in;
        holdD.loadSign  = loadSign_in;
        holdD.pcToReg   = PCtoReg_in;
        holdD.regWrite  = RegWrite_in;
        holdD.memToReg  = MemToReg_in;
        holdD.memWrite  = MemWrite_in;
        if (isWord) begin
            holdD.be    = 4'b1111;
            holdD.wdata = storeData_in;
        end else if (isHalf) begin
            holdD.be    = effOff[0] ? 4'b0011 : 4'b1100;
            holdD.wdata = {2{storeData_in[16:31]}};
        end else begin
            holdD.be    = 4'b1000 >> effOff;
            holdD.wdata = {4{storeData_in[24:31]}};
        end
    end

    // Load-side lane select and extension, using the offset as issued.
    always_comb begin
        heldOff = holdQ.addr[ADDR_W-2:ADDR_W-1];
        case (heldOff)
            2'd0:    laneB = dmem_rdata[0:7];
            2'd1:    laneB = dmem_rdata[8:15];
            2'd2:    laneB = dmem_rdata[16:23];
            default: laneB = dmem_rdata[24:31];
        endcase
        laneH = heldOff[0] ? dmem_rdata[16:31] : dmem_rdata[0:15];
        if (holdQ.dSize[0]) begin
            loadData = dmem_rdata;
        end else if (holdQ.dSize[1]) begin
            loadData = {{16{holdQ.loadSign & laneH[0]}}, laneH};
        end else begin
            loadData = {{24{holdQ.loadSign & laneB[0]}}, laneB};
        end
    end

    assign inAccess   = (stateQ == ACCESS);
    assign timeoutHit = (TIMEOUT > 0) && inAccess && !dmem_ack && (waitCnt == CNT_W'(TO_LAST));
    assign stall_out  = (!inAccess & memOp & !misalign) | (inAccess & !dmem_ack & !timeoutHit);

    assign dmem_req   = inAccess;
    assign dmem_we    = inAccess & holdQ.memWrite;
    assign dmem_addr  = holdQ.addr;
    assign dmem_wdata = holdQ.wdata;
    assign dmem_be    = holdQ.be;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ        <= IDLE;
            waitCnt       <= '0;
            holdQ         <= '0;
            valid_out     <= 1'b0;
            PCtoReg_out   <= 1'b0;
            RegWrite_out  <= 1'b0;
            MemToReg_out  <= 1'b0;
            nextPC_out    <= '0;
            aluResult_out <= '0;
            dataOut_out   <= '0;
            destReg_out   <= '0;
            buserr_out    <= 1'b0;
            misalign_out  <= 1'b0;
        end else begin
            // Bubble unless one of the branches below completes something.
            valid_out     <= 1'b0;
            PCtoReg_out   <= 1'b0;
            RegWrite_out  <= 1'b0;
            MemToReg_out  <= 1'b0;
            nextPC_out    <= '0;
            aluResult_out <= '0;
            dataOut_out   <= '0;
            destReg_out   <= '0;
            buserr_out    <= 1'b0;
            misalign_out  <= 1'b0;
            if (!inAccess) begin
                if (memOp && !misalign) begin
                    holdQ   <= holdD;
                    waitCnt <= '0;
                    stateQ  <= ACCESS;
                end else begin
                    // Pass-through; a trapped misaligned access also lands here.
                    valid_out     <= valid_in;
                    PCtoReg_out   <= PCtoReg_in;
                    RegWrite_out  <= RegWrite_in & !misalign;
                    MemToReg_out  <= MemToReg_in;
                    nextPC_out    <= nextPC_in;
                    aluResult_out <= aluResult_in;
                    destReg_out   <= destReg_in;
                    misalign_out  <= misalign;
                end
            end else if (dmem_ack || timeoutHit) begin
                valid_out     <= 1'b1;
                PCtoReg_out   <= holdQ.pcToReg;
                RegWrite_out  <= holdQ.regWrite & !timeoutHit;
                MemToReg_out  <= holdQ.memToReg;
                nextPC_out    <= holdQ.nextPC;
                aluResult_out <= holdQ.aluResult;
                destReg_out   <= holdQ.destReg;
                dataOut_out   <= dmem_ack ? loadData : '0;
                buserr_out    <= timeoutHit;
                stateQ        <= IDLE;
            end else begin
                waitCnt <= waitCnt + 1'b1;
            end
        end
    end

endmodule
